// File: rtl/sonar_distance_filter.sv
// Converts a ranger echo-width cycle count to centimetres with a restoring divider,
// smooths it with a 4-sample moving average and drives a hysteretic proximity flag.
module sonar_distance_filter #(
    parameter int unsigned COUNT_WIDTH   = 23,
    parameter int unsigned DIST_WIDTH    = 9,
    parameter int unsigned CYCLES_PER_CM = 2900,
    parameter int unsigned NEAR_CM       = 15,
    parameter int unsigned HYST_CM       = 5
) (
    input  logic                   clk,
    input  logic                   reset_all,
    input  logic [COUNT_WIDTH-1:0] count_in,
    input  logic                   count_ready_in,
    output logic [DIST_WIDTH-1:0]  distance_out,
    output logic                   distance_valid_out,
    output logic [DIST_WIDTH-1:0]  raw_distance_out,
    output logic                   near_out,
    output logic                   busy_out,
    output logic                   missed_out
);

    localparam int unsigned REM_W  = $clog2(CYCLES_PER_CM) + 1;
    localparam int unsigned STEP_W = $clog2(COUNT_WIDTH + 1);
    localparam int unsigned SUM_W  = DIST_WIDTH + 2;
    localparam logic [COUNT_WIDTH-1:0] DIST_MAX = COUNT_WIDTH'({DIST_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_AVERAGE,
        S_PUBLISH
    } state_t;

    state_t                 state;
    logic                   ready_q;
    logic [COUNT_WIDTH-1:0] dividend;
    logic [COUNT_WIDTH-1:0] quotient;
    logic [REM_W-1:0]       remainder;
    logic [STEP_W-1:0]      step;
    logic [DIST_WIDTH-1:0]  window [4];
    logic [1:0]             wr_ptr;
    logic [SUM_W-1:0]       sum;
    logic                   primed;

    logic                   capture_c;
    logic [REM_W:0]         trial_c;
    logic                   sub_ok_c;
    logic [REM_W-1:0]       rem_next_c;
    logic [DIST_WIDTH-1:0]  sat_c;
    logic [SUM_W-1:0]       sum_upd_c;
    logic [DIST_WIDTH-1:0]  avg_c;

    // One restoring-division step and the averaging arithmetic
    assign capture_c  = count_ready_in & ~ready_q;
    assign trial_c    = {remainder, dividend[COUNT_WIDTH-1]};
    assign sub_ok_c   = trial_c >= (REM_W+1)'(CYCLES_PER_CM);
    assign rem_next_c = sub_ok_c ? REM_W'(trial_c - (REM_W+1)'(CYCLES_PER_CM))
                                 : REM_W'(trial_c);
    assign sat_c      = (quotient > DIST_MAX) ? {DIST_WIDTH{1'b1}}
                                              : quotient[DIST_WIDTH-1:0];
    assign sum_upd_c  = sum - SUM_W'(window[wr_ptr]) + SUM_W'(sat_c);
    assign avg_c      = sum[SUM_W-1:2];

    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            state              <= S_IDLE;
            ready_q            <= 1'b1;
            dividend           <= '0;
            quotient           <= '0;
            remainder          <= '0;
            step               <= '0;
            for (int i = 0; i < 4; i++) window[i] <= '0;
            wr_ptr             <= '0;
            sum                <= '0;
            primed             <= 1'b0;
            distance_out       <= '0;
            distance_valid_out <= 1'b0;
            raw_distance_out   <= '0;
            near_out           <= 1'b0;
            busy_out           <= 1'b0;
            missed_out         <= 1'b0;
        end else begin
            ready_q            <= count_ready_in;
            distance_valid_out <= 1'b0;
            missed_out         <= capture_c && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (capture_c) begin
                        dividend  <= count_in;
                        quotient  <= '0;
                        remainder <= '0;
                        step      <= STEP_W'(COUNT_WIDTH);
                        busy_out  <= 1'b1;
                        state     <= S_DIVIDE;
                    end
                end

                S_DIVIDE: begin
                    remainder <= rem_next_c;
                    quotient  <= {quotient[COUNT_WIDTH-2:0], sub_ok_c};
                    dividend  <= {dividend[COUNT_WIDTH-2:0], 1'b0};
                    step      <= step - STEP_W'(1);
                    if (step == STEP_W'(1)) state <= S_AVERAGE;
                end

                S_AVERAGE: begin
                    raw_distance_out <= sat_c;
                    if (!primed) begin
                        // First sample seeds the whole window so the average starts settled
                        for (int i = 0; i < 4; i++) window[i] <= sat_c;
                        sum    <= {sat_c, 2'b00};
                        primed <= 1'b1;
                    end else begin
                        sum            <= sum_upd_c;
                        window[wr_ptr] <= sat_c;
                        wr_ptr         <= wr_ptr + 2'd1;
                    end
                    state <= S_PUBLISH;
                end

                S_PUBLISH: begin
                    distance_out       <= avg_c;
                    distance_valid_out <= 1'b1;
                    if (avg_c < DIST_WIDTH'(NEAR_CM))
                        near_out <= 1'b1;
                    else if (avg_c >= DIST_WIDTH'(NEAR_CM + HYST_CM))
                        near_out <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
